instr_fetch_sequencer: RTL and testbench
========================================

# instr_fetch_sequencer

Sequences instruction fetch from the combinational instruction memory: owns the program counter, presents it to the memory, and captures the returned word into a one-entry output register. The register drains to decode through a valid/ready handshake. Redirects (branch/jump/trap targets) come from the execute stage. The block halts on a memory error or a misaligned PC. It sits between the instruction memory and decode, and is the only driver of the memory's `pc_i`.

## Interface
- `RESET_PC`, 64'h0, PC loaded on reset; first fetch address after `start_i`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- `imem_pc_o`  out  64  fetch address to instruction memory; always equals the internal PC register.
- `imem_instr_i`  in  32  instruction word for `imem_pc_o`, combinational, same cycle.
- `imem_error_i`  in  1  memory out-of-range flag for `imem_pc_o`, combinational.
- `redirect_valid_i`  in  1  one-cycle request to load a new PC and flush.
- `redirect_pc_i`  in  64  redirect target.
- `instr_valid_o`  out  1  output register holds a fetched word.
- `instr_o`  out  32  fetched instruction.
- `instr_pc_o`  out  64  address `instr_o` was fetched from.
- `instr_ready_i`  in  1  decode accepts the word when valid & ready at a rising edge.
- `halted_o`  out  1  high while in HALT.
- `fault_pc_o`  out  64  PC that caused the most recent halt.
- `fetch_count_o`  out  32  number of captured words, wraps modulo 2^32.

## Operation
- The FSM has three states: IDLE, RUN and HALT. Reset enters IDLE.
- Reset values:
  - PC = `RESET_PC`.
  - `instr_valid_o`, `instr_o`, `instr_pc_o`, `halted_o`, `fault_pc_o` and `fetch_count_o` are all 0.
- The slot is free in a cycle when `!instr_valid_o || instr_ready_i`.
- IDLE:
  - No capture happens.
  - `start_i` moves to RUN.
  - `redirect_valid_i` loads PC and stays in IDLE.
- RUN, highest priority first:
  1. `redirect_valid_i`: PC <= `redirect_pc_i`, `instr_valid_o` <= 0 (flush), stay in RUN. No capture this cycle.
  2. Fault (`imem_error_i` or PC[1:0] != 0) while the slot is free: go to HALT, `fault_pc_o` <= PC, `halted_o` <= 1. No capture; PC is unchanged. If the handshake completes this cycle, `instr_valid_o` <= 0.
  3. Slot free, no fault: capture.
     - `instr_o` <= `imem_instr_i`, `instr_pc_o` <= PC, `instr_valid_o` <= 1.
     - PC <= PC + 4, modulo 2^64.
     - `fetch_count_o` += 1.
  4. Slot not free: hold all state; `imem_pc_o` stays stable.
- A fault while the slot is not free is not acted on until the slot frees. Faults are evaluated only at capture time.
- HALT:
  - No capture happens.
  - A pending valid word may still drain via the handshake.
  - `redirect_valid_i`: PC <= target, flush, `halted_o` <= 0, go to RUN.
  - `start_i` is ignored.
- Redirect and handshake in the same cycle: the word counts as transferred to decode, and the slot is still cleared.
- `fetch_count_o` is not cleared by redirect or halt; only reset clears it.
- Reset asserted mid-operation returns all state immediately (asynchronously) to reset values, regardless of FSM state.

## Timing
- `start_i` sampled high at edge N: RUN from N, first capture at edge N+1, `instr_valid_o` high after N+1.
- Throughput is one word per cycle with `instr_ready_i` held high. There are no bubbles except after a redirect.
- Redirect at edge R: new PC on `imem_pc_o` after R, target word valid after R+1. The redirect penalty is one bubble cycle.
- Fault detected at edge F: `halted_o` and `fault_pc_o` valid after F.
- `imem_pc_o` changes only at rising edges or asynchronously on reset. It is combinationally independent of all inputs.

## Test plan
- Basic fetch:
  - Stimulus: memory preloaded with 0x00000013, 0x00100093, 0x00200113, 0x00308193 at 0/4/8/12; reset; `start_i` for 1 cycle; ready = 1.
  - Required: valid words 0x00000013@0, 0x00100093@4, 0x00200113@8, 0x00308193@12 on consecutive cycles; `fetch_count_o` = 4.
- Backpressure:
  - Stimulus: ready low for 3 cycles while `instr_o` = 0x00200113@8.
  - Required: `instr_o` and `instr_pc_o` stable, `imem_pc_o` = 12, count frozen; on ready high, the next word is 0x00308193@12.
- Redirect:
  - Stimulus: redirect to 0x10 while the word @4 is pending with ready = 0.
  - Required: valid drops for one cycle; next word is 0x00420213@0x10; the flushed word is never accepted.
- Memory error:
  - Stimulus: redirect to 0x3FC.
  - Required: word@0x3FC delivered; then `imem_error_i` at 0x400 gives `halted_o` = 1 and `fault_pc_o` = 0x400. A following redirect to 0 clears halt, and 0x00000013@0 is delivered.
- Misaligned target:
  - Stimulus: redirect to 0x6.
  - Required: no capture, HALT, `fault_pc_o` = 0x6, `fetch_count_o` unchanged.
- Reset mid-stream:
  - Stimulus: assert `rst_i` between clock edges during RUN with valid high.
  - Required: all outputs immediately at reset values; `imem_pc_o` = `RESET_PC`; IDLE until `start_i`.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_sequencer
// Purpose  : Owns the PC, fetches from combinational imem into a one-entry
//            valid/ready output register; handles redirects and fault halts.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [63:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    input  logic        imem_error_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        halted_o,
    output logic [63:0] fault_pc_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic        halted_q, halted_d;
    logic [63:0] fault_pc_q, fault_pc_d;
    logic [31:0] count_q, count_d;

    logic slot_free;
    logic fault;

    assign slot_free = !valid_q || instr_ready_i;
    assign fault     = imem_error_i || (pc_q[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        halted_d   = halted_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;

        // A completed handshake always empties the slot unless refilled below.
        if (valid_q && instr_ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                end
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                end else if (slot_free && fault) begin
                    state_d    = S_HALT;
                    halted_d   = 1'b1;
                    fault_pc_d = pc_q;
                end else if (slot_free) begin
                    instr_d    = imem_instr_i;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 64'd4;
                    count_d    = count_q + 32'd1;
                end
            end
            S_HALT: begin
                if (redirect_valid_i) begin
                    pc_d     = redirect_pc_i;
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                    state_d  = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= 64'd0;
            halted_q   <= 1'b0;
            fault_pc_q <= 64'd0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            halted_q   <= halted_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign imem_pc_o     = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign halted_o      = halted_q;
    assign fault_pc_o    = fault_pc_q;
    assign fetch_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_sequencer
// Purpose  : Self-checking bench with a behavioural imem and accept scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [63:0] imem_pc_o;
    logic [31:0] imem_instr_i;
    logic        imem_error_i;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'd0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        halted_o;
    logic [63:0] fault_pc_o;
    logic [31:0] fetch_count_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] w;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    always #5 clk_i = ~clk_i;

    assign imem_instr_i = mem[imem_pc_o[9:2]];
    assign imem_error_i = (imem_pc_o >= 64'h400);

    instr_fetch_sequencer #(.RESET_PC(64'h0)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .imem_pc_o        (imem_pc_o),
        .imem_instr_i     (imem_instr_i),
        .imem_error_i     (imem_error_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i),
        .halted_o         (halted_o),
        .fault_pc_o       (fault_pc_o),
        .fetch_count_o    (fetch_count_o)
    );

    task automatic push_exp(input logic [63:0] pc, input logic [31:0] w);
        exp_t e;
        e.pc = pc;
        e.w  = w;
        sb.push_back(e);
    endtask

    // One clock: note whether decode accepts before the edge, check after it.
    task automatic tick();
        logic        acc;
        logic [31:0] a_w;
        logic [63:0] a_pc;
        exp_t        e;
        acc  = instr_valid_o && instr_ready_i;
        a_w  = instr_o;
        a_pc = instr_pc_o;
        @(posedge clk_i);
        #1;
        if (acc) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL accept_unexpected got=%08h@%0h required=none", a_w, a_pc);
            end else begin
                e = sb.pop_front();
                if (a_w !== e.w || a_pc !== e.pc) begin
                    bad++;
                    $display("FAIL accept_word got=%08h@%0h required=%08h@%0h", a_w, a_pc, e.w, e.pc);
                end
            end
        end
    endtask

    task automatic restart();
        rst_i = 1'b1;
        start_i = 1'b0;
        redirect_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        #2;
        rst_i = 1'b0;
        sb.delete();
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        instr_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        tick();
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h required=0", instr_valid_o); end
        total++; if (imem_pc_o !== 64'h0) begin bad++; $display("FAIL rst_pc got=%0h required=0", imem_pc_o); end
        total++; if (instr_o !== 32'h0 || instr_pc_o !== 64'h0) begin bad++; $display("FAIL rst_instr got=%08h@%0h required=0@0", instr_o, instr_pc_o); end
        total++; if (halted_o !== 1'b0 || fault_pc_o !== 64'h0) begin bad++; $display("FAIL rst_halt got=%0h/%0h required=0/0", halted_o, fault_pc_o); end
        total++; if (fetch_count_o !== 32'h0) begin bad++; $display("FAIL rst_count got=%0d required=0", fetch_count_o); end
        restart();
    endtask

    task automatic test_basic_fetch();
        restart();
        instr_ready_i = 1'b1;
        push_exp(64'h0, 32'h00000013);
        push_exp(64'h4, 32'h00100093);
        push_exp(64'h8, 32'h00200113);
        push_exp(64'hC, 32'h00308193);
        start_pulse();
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL basic_no_early_valid got=%0h required=0", instr_valid_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (instr_valid_o !== 1'b1 || instr_pc_o !== 64'(4 * i)) begin
                bad++;
                $display("FAIL basic_stream got=%0h@%0h required=1@%0h", instr_valid_o, instr_pc_o, 4 * i);
            end
        end
        total++; if (fetch_count_o !== 32'd4) begin bad++; $display("FAIL basic_count got=%0d required=4", fetch_count_o); end
        instr_ready_i = 1'b0;
        tick();
        total++; if (fetch_count_o !== 32'd4) begin bad++; $display("FAIL basic_hold_count got=%0d required=4", fetch_count_o); end
        total++; if (sb.size() != 1) begin bad++; $display("FAIL basic_pending got=%0d required=1", sb.size()); end
    endtask

    task automatic test_backpressure();
        restart();
        instr_ready_i = 1'b1;
        push_exp(64'h0, 32'h00000013);
        push_exp(64'h4, 32'h00100093);
        push_exp(64'h8, 32'h00200113);
        push_exp(64'hC, 32'h00308193);
        start_pulse();
        tick();
        tick();
        tick();
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (instr_o !== 32'h00200113 || instr_pc_o !== 64'h8 || imem_pc_o !== 64'hC || fetch_count_o !== 32'd3) begin
                bad++;
                $display("FAIL bp_hold got=%08h@%0h pc=%0h cnt=%0d required=00200113@8 pc=c cnt=3",
                         instr_o, instr_pc_o, imem_pc_o, fetch_count_o);
            end
        end
        instr_ready_i = 1'b1;
        tick();
        total++; if (instr_o !== 32'h00308193 || instr_pc_o !== 64'hC) begin bad++; $display("FAIL bp_next got=%08h@%0h required=00308193@c", instr_o, instr_pc_o); end
        tick();
        instr_ready_i = 1'b0;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_drained got=%0d required=0", sb.size()); end
    endtask

    task automatic test_redirect();
        restart();
        instr_ready_i = 1'b1;
        push_exp(64'h0, 32'h00000013);
        start_pulse();
        tick();
        tick();
        instr_ready_i = 1'b0;
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h10;
        tick();
        redirect_valid_i = 1'b0;
        total++; if (instr_valid_o !== 1'b0 || imem_pc_o !== 64'h10) begin bad++; $display("FAIL redir_flush got=%0h pc=%0h required=0 pc=10", instr_valid_o, imem_pc_o); end
        instr_ready_i = 1'b1;
        push_exp(64'h10, 32'h00420213);
        tick();
        total++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h00420213 || instr_pc_o !== 64'h10) begin bad++; $display("FAIL redir_target got=%0h %08h@%0h required=1 00420213@10", instr_valid_o, instr_o, instr_pc_o); end
        tick();
        instr_ready_i = 1'b0;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL redir_drained got=%0d required=0", sb.size()); end
    endtask

    task automatic test_mem_error();
        restart();
        instr_ready_i = 1'b1;
        start_pulse();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h3FC;
        tick();
        redirect_valid_i = 1'b0;
        push_exp(64'h3FC, 32'h0000006F);
        tick();
        tick();
        total++; if (halted_o !== 1'b1 || fault_pc_o !== 64'h400) begin bad++; $display("FAIL err_halt got=%0h/%0h required=1/400", halted_o, fault_pc_o); end
        total++; if (instr_valid_o !== 1'b0 || fetch_count_o !== 32'd1) begin bad++; $display("FAIL err_state got=%0h cnt=%0d required=0 cnt=1", instr_valid_o, fetch_count_o); end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++; if (halted_o !== 1'b1 || fetch_count_o !== 32'd1) begin bad++; $display("FAIL err_stay got=%0h cnt=%0d required=1 cnt=1", halted_o, fetch_count_o); end
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h0;
        tick();
        redirect_valid_i = 1'b0;
        total++; if (halted_o !== 1'b0 || imem_pc_o !== 64'h0) begin bad++; $display("FAIL err_clear got=%0h pc=%0h required=0 pc=0", halted_o, imem_pc_o); end
        push_exp(64'h0, 32'h00000013);
        tick();
        tick();
        instr_ready_i = 1'b0;
        total++; if (sb.size() != 0 || fetch_count_o !== 32'd3) begin bad++; $display("FAIL err_resume got=%0d cnt=%0d required=0 cnt=3", sb.size(), fetch_count_o); end
    endtask

    task automatic test_misaligned();
        restart();
        instr_ready_i = 1'b1;
        start_pulse();
        push_exp(64'h0, 32'h00000013);
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h6;
        tick();
        redirect_valid_i = 1'b0;
        tick();
        total++; if (halted_o !== 1'b1 || fault_pc_o !== 64'h6) begin bad++; $display("FAIL mis_halt got=%0h/%0h required=1/6", halted_o, fault_pc_o); end
        total++; if (fetch_count_o !== 32'd1 || instr_valid_o !== 1'b0) begin bad++; $display("FAIL mis_nocap got=cnt %0d v %0h required=cnt 1 v 0", fetch_count_o, instr_valid_o); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL mis_drained got=%0d required=0", sb.size()); end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        restart();
        instr_ready_i = 1'b1;
        push_exp(64'h0, 32'h00000013);
        start_pulse();
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        total++; if (instr_valid_o !== 1'b0 || imem_pc_o !== 64'h0 || fetch_count_o !== 32'd0) begin bad++; $display("FAIL midrst_async got=v%0h pc=%0h cnt=%0d required=v0 pc=0 cnt=0", instr_valid_o, imem_pc_o, fetch_count_o); end
        total++; if (instr_o !== 32'h0 || instr_pc_o !== 64'h0 || halted_o !== 1'b0 || fault_pc_o !== 64'h0) begin bad++; $display("FAIL midrst_regs got=%08h@%0h h%0h f%0h required=0", instr_o, instr_pc_o, halted_o, fault_pc_o); end
        rst_i = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) tick();
        total++; if (instr_valid_o !== 1'b0 || imem_pc_o !== 64'h0 || fetch_count_o !== 32'd0) begin bad++; $display("FAIL midrst_idle got=v%0h pc=%0h cnt=%0d required=v0 pc=0 cnt=0", instr_valid_o, imem_pc_o, fetch_count_o); end
        push_exp(64'h0, 32'h00000013);
        start_pulse();
        tick();
        total++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h00000013) begin bad++; $display("FAIL midrst_restart got=%0h %08h required=1 00000013", instr_valid_o, instr_o); end
        tick();
        instr_ready_i = 1'b0;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL midrst_drained got=%0d required=0", sb.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0]   = 32'h00000013;
        mem[1]   = 32'h00100093;
        mem[2]   = 32'h00200113;
        mem[3]   = 32'h00308193;
        mem[4]   = 32'h00420213;
        mem[255] = 32'h0000006F;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect();
        test_mem_error();
        test_misaligned();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
